// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access controller: access modes,
// response error codes, FSM states and the request legality check.
package mem_pkg;

  localparam logic [2:0] MODE_WORD  = 3'd0;
  localparam logic [2:0] MODE_HALF  = 3'd1;
  localparam logic [2:0] MODE_HALFU = 3'd2;
  localparam logic [2:0] MODE_BYTE  = 3'd3;
  localparam logic [2:0] MODE_BYTEU = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_MEM     = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  // Misaligned word/half accesses and undefined mode codes are rejected.
  function automatic logic is_illegal(input logic [2:0] mode, input logic [1:0] addr_lo);
    logic bad;
    case (mode)
      MODE_WORD:              bad = (addr_lo != 2'b00);
      MODE_HALF, MODE_HALFU:  bad = addr_lo[0];
      MODE_BYTE, MODE_BYTEU:  bad = 1'b0;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Lane logic: extracts and extends a load from a memory word, and merges
// store data into the addressed byte/half lane of a memory word.
module mem_lane
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mode,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word[{addr_lo, 3'b000} +: 8];
  assign half_s = addr_lo[1] ? word[31:16] : word[15:0];

  // Load extraction with sign or zero extension.
  always_comb begin
    load_data = 32'h0000_0000;
    case (mode)
      MODE_WORD:  load_data = word;
      MODE_HALF:  load_data = {{16{half_s[15]}}, half_s};
      MODE_HALFU: load_data = {16'h0000, half_s};
      MODE_BYTE:  load_data = {{24{byte_s[7]}}, byte_s};
      MODE_BYTEU: load_data = {24'h00_0000, byte_s};
      default:    load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lane is replaced.
  always_comb begin
    merged = word;
    case (mode)
      MODE_HALF, MODE_HALFU: begin
        if (addr_lo[1]) begin
          merged[31:16] = wdata;
        end else begin
          merged[15:0] = wdata;
        end
      end
      MODE_BYTE, MODE_BYTEU: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      default:               merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a pipeline and a word-wide data memory;
// sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] dm_add,
  output logic [31:0]       dm_data,
  output logic              dm_we,
  output logic [2:0]        dm_mode,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_error
);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [2:0]          mode_r;
  logic [31:0]         dm_data_r;
  logic                resp_valid_r;
  logic [1:0]          resp_err_r;
  logic [31:0]         resp_rdata_r;
  logic                resp_valid_s;
  logic [1:0]          resp_err_s;
  logic [31:0]         resp_rdata_s;
  logic                accept_s;
  logic [31:0]         load_data_s;
  logic [31:0]         merged_s;

  assign req_ready  = (state_r == ST_IDLE);
  assign accept_s   = req_valid && req_ready;
  assign dm_we      = (state_r == ST_WRITE) || (state_r == ST_RMW_WRITE);
  assign dm_add     = {addr_r[ADDR_W-1:2], 2'b00};
  assign dm_data    = dm_data_r;
  assign dm_mode    = MODE_WORD;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

  // dm_data_r holds the store data until RMW_READ, then the merged word.
  mem_lane u_lane (
    .word      (dm_rdata),
    .addr_lo   (addr_r[1:0]),
    .mode      (mode_r),
    .wdata     (dm_data_r[15:0]),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; every non-idle state is a single cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_illegal(req_mode, req_addr[1:0])) begin
            state_s = ST_ERR;
          end else if (!req_we) begin
            state_s = ST_LOAD;
          end else if (req_mode == MODE_WORD) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_RMW_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD:      state_s = ST_IDLE;
      ST_WRITE:     state_s = ST_IDLE;
      ST_RMW_READ:  state_s = ST_RMW_WRITE;
      ST_RMW_WRITE: state_s = ST_IDLE;
      ST_ERR:       state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Response values registered on the edge that leaves a working state.
  always_comb begin
    resp_valid_s = 1'b0;
    resp_err_s   = ERR_OK;
    resp_rdata_s = 32'h0000_0000;
    case (state_r)
      ST_LOAD: begin
        resp_valid_s = 1'b1;
        resp_rdata_s = load_data_s;
      end
      ST_WRITE, ST_RMW_WRITE: begin
        resp_valid_s = 1'b1;
        resp_err_s   = dm_error ? ERR_MEM : ERR_OK;
      end
      ST_ERR: begin
        resp_valid_s = 1'b1;
        resp_err_s   = ERR_ILLEGAL;
      end
      default: begin
        resp_valid_s = 1'b0;
        resp_err_s   = ERR_OK;
        resp_rdata_s = 32'h0000_0000;
      end
    endcase
  end

  // Request latch, merge register and registered response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r       <= '0;
      mode_r       <= MODE_WORD;
      dm_data_r    <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= ERR_OK;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      if (accept_s) begin
        addr_r    <= req_addr;
        mode_r    <= req_mode;
        dm_data_r <= req_wdata;
      end else if (state_r == ST_RMW_READ) begin
        dm_data_r <= merged_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small word memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [15:0] dm_add;
  logic [31:0] dm_data;
  logic        dm_we;
  logic [2:0]  dm_mode;
  logic [31:0] dm_rdata;
  logic        dm_error;

  logic [31:0] mem [0:16383];
  logic        pre_we = 1'b0;
  logic [13:0] pre_idx = 14'd0;
  logic [31:0] pre_val = 32'd0;
  int          we_count = 0;
  int          resp_count = 0;
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_add(dm_add), .dm_data(dm_data), .dm_we(dm_we), .dm_mode(dm_mode),
    .dm_rdata(dm_rdata), .dm_error(dm_error)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_add[15:2]];
  assign dm_error = dm_we && (dm_add >= 16'h3000);

  // Memory model: backdoor preload or in-range write.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_val;
    end else if (dm_we && !dm_error) begin
      mem[dm_add[15:2]] <= dm_data;
    end
  end

  // Count write-enable cycles and responses.
  always @(posedge clk) begin
    if (dm_we) we_count <= we_count + 1;
    if (resp_valid) resp_count <= resp_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [13:0] idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request from IDLE; lat = edges after the acceptance edge until resp_valid.
  task automatic run_req(input logic we, input logic [2:0] mode, input logic [15:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic [1:0] err);
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  int          lat;
  int          w0;
  int          r0;
  logic [31:0] rd;
  logic [1:0]  er;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0;
    req_addr = 16'h0000; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_add", 32'(dm_add), 32'd0);
    check("rst_dm_data", dm_data, 32'd0);
    check("rst_resp", {28'd0, resp_err, 2'b00} | resp_rdata, 32'd0);
    check("dm_mode", 32'(dm_mode), 32'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Word store then word load
    w0 = we_count;
    run_req(1'b1, 3'd0, 16'h0010, 32'hDEADBEEF, lat, rd, er);
    check("wst_lat", lat, 32'd1);
    check("wst_err", 32'(er), 32'd0);
    check("wst_we_pulses", we_count - w0, 32'd1);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    run_req(1'b0, 3'd0, 16'h0010, 32'h0, lat, rd, er);
    check("wld_lat", lat, 32'd1);
    check("wld_data", rd, 32'hDEADBEEF);

    // Byte store via read-modify-write, then byte loads
    preload(14'd8, 32'h11223344);
    w0 = we_count;
    run_req(1'b1, 3'd3, 16'h0022, 32'h000000AB, lat, rd, er);
    check("bst_lat", lat, 32'd2);
    check("bst_err", 32'(er), 32'd0);
    check("bst_we_pulses", we_count - w0, 32'd1);
    check("bst_mem", mem[8], 32'h11AB3344);
    run_req(1'b0, 3'd3, 16'h0022, 32'h0, lat, rd, er);
    check("bld_data", rd, 32'hFFFFFFAB);
    run_req(1'b0, 3'd4, 16'h0022, 32'h0, lat, rd, er);
    check("buld_data", rd, 32'h000000AB);

    // Half loads, half store, top-byte load
    preload(14'd8, 32'h8001FFFF);
    run_req(1'b0, 3'd1, 16'h0022, 32'h0, lat, rd, er);
    check("hld_data", rd, 32'hFFFF8001);
    run_req(1'b0, 3'd2, 16'h0022, 32'h0, lat, rd, er);
    check("huld_data", rd, 32'h00008001);
    run_req(1'b1, 3'd1, 16'h0020, 32'hCDEF1234, lat, rd, er);
    check("hst_mem", mem[8], 32'h80011234);
    run_req(1'b0, 3'd3, 16'h0023, 32'h0, lat, rd, er);
    check("bld_top", rd, 32'hFFFFFF80);
    run_req(1'b0, 3'd4, 16'h0021, 32'h0, lat, rd, er);
    check("buld_b1", rd, 32'h00000012);

    // Illegal requests
    w0 = we_count;
    run_req(1'b0, 3'd0, 16'h0011, 32'h0, lat, rd, er);
    check("mis_word_lat", lat, 32'd1);
    check("mis_word_err", 32'(er), 32'd1);
    check("mis_word_rdata", rd, 32'd0);
    run_req(1'b0, 3'd6, 16'h0010, 32'h0, lat, rd, er);
    check("mode6_err", 32'(er), 32'd1);
    run_req(1'b1, 3'd1, 16'h0021, 32'h5555, lat, rd, er);
    check("mis_half_err", 32'(er), 32'd1);
    check("illegal_no_we", we_count - w0, 32'd0);

    // Memory error on store
    run_req(1'b1, 3'd0, 16'h3000, 32'h12345678, lat, rd, er);
    check("memerr_err", 32'(er), 32'd2);
    check("memerr_rdata", rd, 32'd0);
    run_req(1'b0, 3'd0, 16'h0010, 32'h0, lat, rd, er);
    check("after_memerr_err", 32'(er), 32'd0);

    // Reset during RMW_WRITE abandons the store
    preload(14'd9, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_mode = 3'd3; req_addr = 16'h0024; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_read_no_we", 32'(dm_we), 32'd0);
    @(posedge clk); #1;
    check("rmw_write_we", 32'(dm_we), 32'd1);
    check("rmw_write_data", dm_data, 32'hCAFEF055);
    w0 = we_count; r0 = resp_count;
    rstn = 1'b0;
    #1;
    check("rst_drop_we", 32'(dm_we), 32'd0);
    check("rst_drop_data", dm_data, 32'd0);
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_write", we_count - w0, 32'd0);
    check("rst_no_resp", resp_count - r0, 32'd0);
    check("rst_mem_kept", mem[9], 32'hCAFEF00D);

    // Back-to-back loads with req_valid held high
    r0 = resp_count;
    req_valid = 1'b1; req_we = 1'b0; req_mode = 3'd0; req_addr = 16'h0010;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("b2b_ready", 32'(req_ready), 32'(i % 2));
      check("b2b_resp", 32'(resp_valid), 32'(i % 2));
      if (resp_valid) check("b2b_data", resp_rdata, 32'hDEADBEEF);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_count", resp_count - r0, 32'd3);
    check("b2b_idle", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
